// File: rtl/sram_pkg.sv
// Shared definitions for the Wishbone-to-async-SRAM bridge.
//   sram_state_t     : access sequencer states
//   *_DEFAULT        : default SRAM word-address width and data width
//   BYTE_LANES       : byte lanes for the default data width
//   addr_in_window() : bank-window match on the upper byte-address bits
//                      (only used when WB_SRAM_ERR_EN is defined)
package sram_pkg;

  localparam int SRAM_ADDR_WIDTH_DEFAULT = 20;
  localparam int DATA_WIDTH_DEFAULT      = 32;
  localparam int BYTE_LANES              = DATA_WIDTH_DEFAULT / 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD1,
    ST_RD2,
    ST_WR1,
    ST_WR2,
    ST_DONE
  } sram_state_t;

  // True when adr falls in the same bank window as base. The window is
  // 2^(aw+2) bytes, so only the bits above the word address are compared.
  function automatic logic addr_in_window(input logic [31:0] adr,
                                          input logic [31:0] base,
                                          input int          aw);
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF << (aw + 2);
    return ((adr ^ base) & mask) == 32'h0;
  endfunction

endpackage

// File: rtl/wb_sram_ctrl.sv
// Wishbone classic slave driving one asynchronous 1Mx32 SRAM bank.
// Every access runs IDLE -> RD1/WR1 -> RD2/WR2 -> DONE, with ack in DONE.
// All SRAM pins come straight from flops.
//
// Ports:
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   wb_cyc_i/stb_i/we_i : Wishbone cycle, strobe, write enable
//   wb_adr_i            : byte address, word bits [SRAM_ADDR_WIDTH+1:2]
//   wb_sel_i, wb_dat_i  : byte-lane select and write data
//   wb_dat_o            : registered read data (held until the next read)
//   wb_ack_o, wb_err_o  : one-cycle acknowledge and error acknowledge
//   sram_addr           : SRAM word address
//   sram_data           : bidirectional SRAM data bus
//   sram_ce_n/oe_n/we_n : chip, output and write enables (active-low)
//   sram_be_n           : byte enables (active-low)
//
// Build option: define WB_SRAM_ERR_EN to answer misaligned or out-of-bank
// requests with wb_err_o instead of an SRAM access. Otherwise wb_err_o is 0.
module wb_sram_ctrl
  import sram_pkg::*;
#(
  parameter int          SRAM_ADDR_WIDTH = SRAM_ADDR_WIDTH_DEFAULT,
  parameter int          DATA_WIDTH      = DATA_WIDTH_DEFAULT,
  parameter logic [31:0] BANK_BASE       = 32'h8000_0000
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wb_cyc_i,
  input  logic                       wb_stb_i,
  input  logic                       wb_we_i,
  input  logic [31:0]                wb_adr_i,
  input  logic [DATA_WIDTH/8-1:0]    wb_sel_i,
  input  logic [DATA_WIDTH-1:0]      wb_dat_i,
  output logic [DATA_WIDTH-1:0]      wb_dat_o,
  output logic                       wb_ack_o,
  output logic                       wb_err_o,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  inout  wire  [DATA_WIDTH-1:0]      sram_data,
  output logic                       sram_ce_n,
  output logic                       sram_oe_n,
  output logic                       sram_we_n,
  output logic [DATA_WIDTH/8-1:0]    sram_be_n
);

  localparam int LANES = DATA_WIDTH / 8;

  sram_state_t                state_q, state_d;
  logic                       ce_n_q, ce_n_d;
  logic                       oe_n_q, oe_n_d;
  logic                       we_n_q, we_n_d;
  logic [LANES-1:0]           be_n_q, be_n_d;
  logic                       drive_q, drive_d;
  logic                       ack_q, ack_d;
  logic                       err_q, err_d;
  logic [SRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]      dat_o_q, dat_o_d;
  logic [LANES-1:0]           sel_q, sel_d;
  logic [DATA_WIDTH-1:0]      wdat_q, wdat_d;
  logic                       req;
  logic                       addr_bad;

  assign req = wb_cyc_i & wb_stb_i;

`ifdef WB_SRAM_ERR_EN
  assign addr_bad = (wb_adr_i[1:0] != 2'b00) ||
                    !addr_in_window(wb_adr_i, BANK_BASE, SRAM_ADDR_WIDTH);
  assign wb_err_o = err_q;
`else
  logic unused_ok;
  assign addr_bad  = 1'b0;
  assign wb_err_o  = 1'b0;
  assign unused_ok = ^{wb_adr_i[31:SRAM_ADDR_WIDTH+2], wb_adr_i[1:0],
                       BANK_BASE, err_q};
`endif

  always_comb begin
    state_d = state_q;
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    be_n_d  = '1;
    drive_d = 1'b0;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    addr_d  = addr_q;
    dat_o_d = dat_o_q;
    sel_d   = sel_q;
    wdat_d  = wdat_q;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d = wb_adr_i[SRAM_ADDR_WIDTH+1:2];
          sel_d  = wb_sel_i;
          wdat_d = wb_dat_i;
          if (addr_bad) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end else if (wb_we_i) begin
            state_d = ST_WR1;
          end else begin
            state_d = ST_RD1;
          end
        end
      end
      ST_RD1:  state_d = wb_cyc_i ? ST_RD2 : ST_IDLE;
      ST_RD2: begin
        if (wb_cyc_i) begin
          state_d = ST_DONE;
          ack_d   = 1'b1;
          dat_o_d = sram_data;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR1:  state_d = wb_cyc_i ? ST_WR2 : ST_IDLE;
      ST_WR2: begin
        if (wb_cyc_i) begin
          state_d = ST_DONE;
          ack_d   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Pin flops take the values of the state being entered, so the strobes
    // line up with the state register without any combinational path.
    case (state_d)
      ST_RD1, ST_RD2: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
        be_n_d = '0;
      end
      ST_WR1: begin
        ce_n_d  = 1'b0;
        we_n_d  = 1'b0;
        be_n_d  = ~sel_d;
        drive_d = 1'b1;
      end
      // WE already high again; data and byte enables held for hold time.
      ST_WR2: begin
        ce_n_d  = 1'b0;
        be_n_d  = ~sel_d;
        drive_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      be_n_q  <= '1;
      drive_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      dat_o_q <= '0;
    end else begin
      state_q <= state_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      be_n_q  <= be_n_d;
      drive_q <= drive_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      dat_o_q <= dat_o_d;
    end
  end

  // Write payload is only consumed while drive_q is set, so it needs no reset.
  always_ff @(posedge clk_i) begin
    sel_q  <= sel_d;
    wdat_q <= wdat_d;
  end

  assign sram_data = drive_q ? wdat_q : {DATA_WIDTH{1'bz}};
  assign sram_addr = addr_q;
  assign sram_ce_n = ce_n_q;
  assign sram_oe_n = oe_n_q;
  assign sram_we_n = we_n_q;
  assign sram_be_n = be_n_q;
  assign wb_dat_o  = dat_o_q;
  assign wb_ack_o  = ack_q;

endmodule
